// File: rtl/video_mode_config.sv
// -----------------------------------------------------------------------------
// video_mode_config
//
// Chooses the output video mode from the force, sense and user inputs,
// debounces that choice, and then reprograms the external clock generator.
// A mode is committed only after it has stayed unchanged for STABLE_CYCLES
// cycles. A commit asserts reconfig_req. The block then waits for
// reconfig_ack, or gives up after ACK_TIMEOUT cycles. It then waits a further
// HOLDOFF_CYCLES settle cycles before raising config_valid again. All outputs
// are registered.
//
// Ports:
//   clock            system clock
//   reset            synchronous, active-high reset (restarts mode-0 programming)
//   cfg_table        flattened clock-config per mode, entry k at [k*CFG_W +: CFG_W]
//   ld_mask          line-doubler enable per mode
//   force_generate   force progressive mode 1
//   force_vga        force progressive mode 1
//   sense_480p_n     sensed external 480p pin (active low)
//   user_mode        requested mode when nothing forces progressive
//   reconfig_ack     clock generator finished reprogramming
//   clock_config_S   committed clock-generator S-pin setting
//   line_doubler     committed line-doubler enable
//   drive_480p_low   tristate enable that pulls the 480p pin low
//   reconfig_req     request to the clock generator to reprogram
//   config_valid     outputs have settled; downstream may run
//   config_changed   one-cycle pulse per completed reconfiguration
//   active_mode      committed mode index
//   ack_timeout_err  sticky flag: an ack timed out
// -----------------------------------------------------------------------------
module video_mode_config #(
    parameter int NUM_MODES      = 4,
    parameter int CFG_W          = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int ACK_TIMEOUT    = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_MODES*CFG_W-1:0]   cfg_table,
    input  logic [NUM_MODES-1:0]         ld_mask,
    input  logic                         force_generate,
    input  logic                         force_vga,
    input  logic                         sense_480p_n,
    input  logic [$clog2(NUM_MODES)-1:0] user_mode,
    input  logic                         reconfig_ack,
    output logic [CFG_W-1:0]             clock_config_S,
    output logic                         line_doubler,
    output logic                         drive_480p_low,
    output logic                         reconfig_req,
    output logic                         config_valid,
    output logic                         config_changed,
    output logic [$clog2(NUM_MODES)-1:0] active_mode,
    output logic                         ack_timeout_err
);

    localparam int MODE_W   = $clog2(NUM_MODES);
    localparam int STABLE_W = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int HOLD_W   = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int TO_W     = (ACK_TIMEOUT    > 1) ? $clog2(ACK_TIMEOUT)    : 1;

    localparam logic [STABLE_W-1:0] STABLE_MAX   = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX     = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_MAX       = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [MODE_W-1:0]   MODE_DEFAULT = MODE_W'(0);
    localparam logic [MODE_W-1:0]   MODE_PROG    = MODE_W'(1);
    // One extra bit so that NUM_MODES itself is representable for the range check
    localparam logic [MODE_W:0]     MODE_COUNT   = (MODE_W + 1)'(NUM_MODES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

    state_t              state_r;
    logic [MODE_W-1:0]   pending_r;
    logic [STABLE_W-1:0] stable_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [TO_W-1:0]     timeout_cnt_r;
    logic [MODE_W-1:0]   active_mode_r;
    logic [CFG_W-1:0]    clock_config_r;
    logic                line_doubler_r;
    logic                drive_480p_low_r;
    logic                reconfig_req_r;
    logic                config_valid_r;
    logic                config_changed_r;
    logic                ack_timeout_err_r;

    logic [MODE_W-1:0]   cand_s;
    logic                cand_forced_s;
    logic [CFG_W-1:0]    cfg_sel_s;
    logic                ld_sel_s;

    // Candidate mode: a forced or sensed 480p request overrides the user choice.
    // An out-of-range user request falls back to the default mode.
    always_comb begin
        cand_forced_s = force_generate | force_vga;
        cand_s        = MODE_DEFAULT;
        if (cand_forced_s | ~sense_480p_n) begin
            cand_s = MODE_PROG;
        end else if ({1'b0, user_mode} < MODE_COUNT) begin
            cand_s = user_mode;
        end else begin
            cand_s = MODE_DEFAULT;
        end
    end

    // Table lookup for the pending mode, sampled only when a commit happens
    always_comb begin
        cfg_sel_s = cfg_table[pending_r*CFG_W +: CFG_W];
        ld_sel_s  = ld_mask[pending_r];
    end

    // Debounce, commit and clock-generator handshake sequencer
    always_ff @(posedge clock) begin
        if (reset) begin
            // Start in REQ so that mode 0 is always programmed after reset
            state_r           <= ST_REQ;
            pending_r         <= MODE_DEFAULT;
            stable_cnt_r      <= '0;
            hold_cnt_r        <= '0;
            timeout_cnt_r     <= '0;
            active_mode_r     <= MODE_DEFAULT;
            clock_config_r    <= cfg_table[CFG_W-1:0];
            line_doubler_r    <= ld_mask[0];
            drive_480p_low_r  <= 1'b0;
            reconfig_req_r    <= 1'b1;
            config_valid_r    <= 1'b0;
            config_changed_r  <= 1'b0;
            ack_timeout_err_r <= 1'b0;
        end else begin
            config_changed_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((stable_cnt_r == STABLE_MAX) && (pending_r != active_mode_r)) begin
                        state_r          <= ST_REQ;
                        active_mode_r    <= pending_r;
                        clock_config_r   <= cfg_sel_s;
                        line_doubler_r   <= ld_sel_s;
                        // Drive the pin only for a forced request; a merely
                        // sensed 480p request must not hold itself on
                        drive_480p_low_r <= (pending_r == MODE_PROG) & cand_forced_s;
                        reconfig_req_r   <= 1'b1;
                        config_valid_r   <= 1'b0;
                        timeout_cnt_r    <= '0;
                    end else begin
                        if (cand_s != pending_r) begin
                            pending_r    <= cand_s;
                            stable_cnt_r <= '0;
                        end else if (stable_cnt_r != STABLE_MAX) begin
                            stable_cnt_r <= stable_cnt_r + 1'b1;
                        end
                        // While in progressive mode the pin drive follows the force
                        // inputs directly. Once the force is released the sensed
                        // pin goes back high, and the mode can drop back.
                        if (active_mode_r == MODE_PROG) begin
                            drive_480p_low_r <= cand_forced_s;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack wins over a timeout that falls in the same cycle
                    if (reconfig_ack) begin
                        reconfig_req_r <= 1'b0;
                        timeout_cnt_r  <= '0;
                        hold_cnt_r     <= '0;
                        state_r        <= ST_HOLDOFF;
                    end else if (timeout_cnt_r == TO_MAX) begin
                        reconfig_req_r    <= 1'b0;
                        ack_timeout_err_r <= 1'b1;
                        timeout_cnt_r     <= '0;
                        hold_cnt_r        <= '0;
                        state_r           <= ST_HOLDOFF;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_r == HOLD_MAX) begin
                        config_valid_r   <= 1'b1;
                        config_changed_r <= 1'b1;
                        hold_cnt_r       <= '0;
                        stable_cnt_r     <= '0;
                        pending_r        <= active_mode_r;
                        state_r          <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: reprogram the committed mode again
                    state_r        <= ST_REQ;
                    reconfig_req_r <= 1'b1;
                    config_valid_r <= 1'b0;
                    timeout_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign clock_config_S  = clock_config_r;
    assign line_doubler    = line_doubler_r;
    assign drive_480p_low  = drive_480p_low_r;
    assign reconfig_req    = reconfig_req_r;
    assign config_valid    = config_valid_r;
    assign config_changed  = config_changed_r;
    assign active_mode     = active_mode_r;
    assign ack_timeout_err = ack_timeout_err_r;

endmodule

// File: tb/tb_video_mode_config.sv
// -----------------------------------------------------------------------------
// tb_video_mode_config
//
// Directed testbench for video_mode_config. It uses STABLE=4, HOLDOFF=8 and
// TIMEOUT=16. The table is cfg_table = {C,9,5,2} and ld_mask = 4'b1101.
// Outputs are sampled 1 time unit after each rising edge. Inputs change at
// that same point. The "status" vector packs every output:
//   {cfg[3:0], ld, drive, req, valid, changed, err, active[1:0]}
// -----------------------------------------------------------------------------
module tb_video_mode_config;

    logic        clock;
    logic        reset;
    logic [15:0] cfg_table;
    logic [3:0]  ld_mask;
    logic        force_generate;
    logic        force_vga;
    logic        sense_480p_n;
    logic [1:0]  user_mode;
    logic        reconfig_ack;
    logic [3:0]  clock_config_S;
    logic        line_doubler;
    logic        drive_480p_low;
    logic        reconfig_req;
    logic        config_valid;
    logic        config_changed;
    logic [1:0]  active_mode;
    logic        ack_timeout_err;

    logic [11:0] status;
    int          tests_run;
    int          tests_failed;

    video_mode_config #(
        .NUM_MODES     (4),
        .CFG_W         (4),
        .STABLE_CYCLES (4),
        .HOLDOFF_CYCLES(8),
        .ACK_TIMEOUT   (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_table      (cfg_table),
        .ld_mask        (ld_mask),
        .force_generate (force_generate),
        .force_vga      (force_vga),
        .sense_480p_n   (sense_480p_n),
        .user_mode      (user_mode),
        .reconfig_ack   (reconfig_ack),
        .clock_config_S (clock_config_S),
        .line_doubler   (line_doubler),
        .drive_480p_low (drive_480p_low),
        .reconfig_req   (reconfig_req),
        .config_valid   (config_valid),
        .config_changed (config_changed),
        .active_mode    (active_mode),
        .ack_timeout_err(ack_timeout_err)
    );

    assign status = {clock_config_S, line_doubler, drive_480p_low, reconfig_req,
                     config_valid, config_changed, ack_timeout_err, active_mode};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One-cycle ack followed by the full 8-cycle holdoff
    task automatic ack_and_settle();
        reconfig_ack = 1'b1;
        tick(1);
        reconfig_ack = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        reset = 1'b1;
        tick(2);
        exp = {4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL reset_state: status=%b expected=%b", status, exp); end
        reset = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick(1);
            tests_run++;
            if (reconfig_req !== 1'b1) begin tests_failed++; $display("FAIL reset_req_cycle%0d: req=%b expected=1", i, reconfig_req); end
        end
        reconfig_ack = 1'b1;
        tick(1);
        reconfig_ack = 1'b0;
        exp = {4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL reset_ack: status=%b expected=%b", status, exp); end
        tick(7);
        tests_run++;
        if (config_valid !== 1'b0 || config_changed !== 1'b0) begin tests_failed++; $display("FAIL reset_holdoff: valid=%b changed=%b expected 0 0", config_valid, config_changed); end
        tick(1);
        exp = {4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL reset_valid: status=%b expected=%b", status, exp); end
        tick(1);
        tests_run++;
        if (config_valid !== 1'b1 || config_changed !== 1'b0) begin tests_failed++; $display("FAIL reset_single_pulse: valid=%b changed=%b expected 1 0", config_valid, config_changed); end
    endtask

    task automatic test_force_vga();
        logic [11:0] exp;
        force_vga = 1'b1;
        tick(4);
        exp = {4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL vga_debounce: status=%b expected=%b", status, exp); end
        tick(1);
        exp = {4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL vga_commit: status=%b expected=%b", status, exp); end
        ack_and_settle();
        exp = {4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL vga_settled: status=%b expected=%b", status, exp); end
        force_vga    = 1'b0;
        sense_480p_n = 1'b1;
        tick(1);
        exp = {4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL vga_drop_drive: status=%b expected=%b", status, exp); end
        tick(3);
        tests_run++;
        if (reconfig_req !== 1'b0) begin tests_failed++; $display("FAIL vga_drop_debounce: req=%b expected=0", reconfig_req); end
        tick(1);
        exp = {4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL vga_back_mode0: status=%b expected=%b", status, exp); end
        ack_and_settle();
        exp = {4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL vga_mode0_settled: status=%b expected=%b", status, exp); end
    endtask

    task automatic test_glitch();
        logic [11:0] exp;
        user_mode = 2'd2;
        tick(3);
        user_mode = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            tests_run++;
            if (reconfig_req !== 1'b0 || config_changed !== 1'b0) begin tests_failed++; $display("FAIL glitch_ignored%0d: req=%b changed=%b expected 0 0", i, reconfig_req, config_changed); end
        end
        user_mode = 2'd2;
        tick(4);
        tests_run++;
        if (reconfig_req !== 1'b0) begin tests_failed++; $display("FAIL glitch_hold3: req=%b expected=0", reconfig_req); end
        tick(1);
        exp = {4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL glitch_commit: status=%b expected=%b", status, exp); end
        ack_and_settle();
    endtask

    task automatic test_ack_timeout_same_cycle();
        logic [11:0] exp;
        user_mode = 2'd3;
        tick(5);
        exp = {4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL same_commit: status=%b expected=%b", status, exp); end
        tick(15);
        tests_run++;
        if (reconfig_req !== 1'b1) begin tests_failed++; $display("FAIL same_req15: req=%b expected=1", reconfig_req); end
        reconfig_ack = 1'b1;
        tick(1);
        reconfig_ack = 1'b0;
        exp = {4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL same_cycle_no_err: status=%b expected=%b", status, exp); end
        tick(8);
        exp = {4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL same_settled: status=%b expected=%b", status, exp); end
    endtask

    task automatic test_timeout();
        logic [11:0] exp;
        user_mode = 2'd1;
        tick(5);
        exp = {4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL to_commit: status=%b expected=%b", status, exp); end
        tick(15);
        tests_run++;
        if (reconfig_req !== 1'b1 || ack_timeout_err !== 1'b0) begin tests_failed++; $display("FAIL to_wait15: req=%b err=%b expected 1 0", reconfig_req, ack_timeout_err); end
        tick(1);
        exp = {4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL to_err: status=%b expected=%b", status, exp); end
        tick(7);
        tests_run++;
        if (config_valid !== 1'b0) begin tests_failed++; $display("FAIL to_holdoff: valid=%b expected=0", config_valid); end
        tick(1);
        exp = {4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL to_valid: status=%b expected=%b", status, exp); end
        tick(3);
        tests_run++;
        if (ack_timeout_err !== 1'b1) begin tests_failed++; $display("FAIL to_sticky: err=%b expected=1", ack_timeout_err); end
    endtask

    task automatic test_reset_in_holdoff();
        logic [11:0] exp;
        user_mode = 2'd3;
        tick(5);
        exp = {4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL abort_commit: status=%b expected=%b", status, exp); end
        reconfig_ack = 1'b1;
        tick(1);
        reconfig_ack = 1'b0;
        tick(3);
        reset     = 1'b1;
        user_mode = 2'd0;
        tick(1);
        reset = 1'b0;
        exp = {4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL reset_abort: status=%b expected=%b", status, exp); end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            tests_run++;
            if (config_changed !== 1'b0 || reconfig_req !== 1'b1) begin tests_failed++; $display("FAIL abort_no_pulse%0d: changed=%b req=%b expected 0 1", i, config_changed, reconfig_req); end
        end
        ack_and_settle();
        exp = {4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL abort_recover: status=%b expected=%b", status, exp); end
    endtask

    task automatic test_change_during_req();
        logic [11:0] exp;
        user_mode = 2'd2;
        tick(5);
        exp = {4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL chg_commit: status=%b expected=%b", status, exp); end
        user_mode = 2'd3;
        tick(2);
        ack_and_settle();
        exp = {4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL chg_ignored: status=%b expected=%b", status, exp); end
        tick(4);
        tests_run++;
        if (reconfig_req !== 1'b0 || active_mode !== 2'd2) begin tests_failed++; $display("FAIL chg_debounce: req=%b active=%0d expected 0 2", reconfig_req, active_mode); end
        tick(1);
        exp = {4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
        tests_run++;
        if (status !== exp) begin tests_failed++; $display("FAIL chg_late_commit: status=%b expected=%b", status, exp); end
        ack_and_settle();
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        cfg_table      = 16'hC952;
        ld_mask        = 4'b1101;
        force_generate = 1'b0;
        force_vga      = 1'b0;
        sense_480p_n   = 1'b1;
        user_mode      = 2'd0;
        reconfig_ack   = 1'b0;

        test_reset();
        test_force_vga();
        test_glitch();
        test_ack_timeout_same_cycle();
        test_timeout();
        test_reset_in_holdoff();
        test_change_during_req();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/video_mode_config.md
Name: video_mode_config

Overview:
- Parametrised video-mode configuration controller with one clock domain.
- Selects one of NUM_MODES output modes from force, sense and user inputs, and debounces the selection.
- Sequences a clock-generator reprogramming handshake, then signals completion.
- Sits between the Dreamcast video-timing/config sources and the external clock generator S-pins and line-doubler datapath.

Parameters:
NUM_MODES, 4, number of mode table entries (>=2); mode 0 = interlaced/default, mode 1 = progressive 480p
CFG_W, 4, width of one clock-config table entry (clock_config_S width)
STABLE_CYCLES, 16, cycles a candidate mode must persist before commit (>=1)
HOLDOFF_CYCLES, 256, settle cycles after ack/timeout before config_valid rises (>=1)
ACK_TIMEOUT, 1024, max cycles waiting for reconfig_ack (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_table  in  NUM_MODES*CFG_W  flattened clock-config per mode; entry k at [k*CFG_W +: CFG_W]
ld_mask  in  NUM_MODES  line_doubler value per mode
force_generate  in  1  force mode 1
force_vga  in  1  force mode 1
sense_480p_n  in  1  external 480p pin, sensed (active low)
user_mode  in  $clog2(NUM_MODES)  requested mode when nothing forces progressive
reconfig_ack  in  1  clock generator done
clock_config_S  out  CFG_W  committed clock-generator setting
line_doubler  out  1  committed line-doubler enable
drive_480p_low  out  1  tristate enable: drive 480p pin low
reconfig_req  out  1  request clock generator reprogram
config_valid  out  1  outputs settled, downstream may run
config_changed  out  1  one-cycle pulse per completed reconfiguration
active_mode  out  $clog2(NUM_MODES)  committed mode index
ack_timeout_err  out  1  sticky: an ack timed out

Behaviour:
- Candidate mode, combinational:
  - If force_generate | force_vga | ~sense_480p_n, candidate is 1.
  - Else if user_mode < NUM_MODES, candidate is user_mode.
  - Else candidate is 0.
- Candidate source flag cand_forced = force_generate | force_vga.
- Debounce, IDLE state only:
  - If candidate != pending, pending <= candidate and stable_cnt <= 0.
  - Otherwise stable_cnt saturates at STABLE_CYCLES-1.
  - When stable_cnt == STABLE_CYCLES-1 and pending != active_mode, go to REQ next cycle.
  - With STABLE_CYCLES=1, a candidate present for 1 cycle commits.
- States: IDLE, REQ, HOLDOFF.
- IDLE -> REQ:
  - active_mode <= pending; clock_config_S <= cfg_table[pending]; line_doubler <= ld_mask[pending].
  - drive_480p_low <= (pending==1) & cand_forced.
  - reconfig_req <= 1; config_valid <= 0.
- REQ:
  - timeout_cnt increments each cycle.
  - If reconfig_ack sampled high: reconfig_req <= 0, go to HOLDOFF.
  - Else if timeout_cnt == ACK_TIMEOUT-1: reconfig_req <= 0, ack_timeout_err <= 1 (sticky until reset), go to HOLDOFF.
  - Ack has priority over timeout in the same cycle (no error).
- HOLDOFF:
  - hold_cnt counts HOLDOFF_CYCLES cycles.
  - On the last cycle: config_valid <= 1, config_changed <= 1 for exactly one cycle, go to IDLE with stable_cnt <= 0 and pending <= active_mode.
- Candidate changes during REQ/HOLDOFF are ignored; they are re-evaluated in IDLE, where debounce restarts.
- drive_480p_low updates in IDLE while active_mode==1, following cand_forced without reconfiguration. This prevents self-latching through the sensed pin.
- Reset (synchronous, any state, mid-handshake included):
  - active_mode=0, pending=0, clock_config_S=cfg_table[0], line_doubler=ld_mask[0].
  - drive_480p_low=0, config_valid=0, config_changed=0, ack_timeout_err=0, all counters 0.
  - state=REQ, reconfig_req=1 on the first cycle after reset, so mode 0 is always programmed at start.
- cfg_table and ld_mask are sampled only on entry to REQ; later changes take effect on the next commit.
- Counter widths are $clog2 of their maximum (minimum 1 bit). No counter wraps; all saturate or reset.

Test Plan:
Params NUM_MODES=4, CFG_W=4, STABLE=4, HOLDOFF=8, TIMEOUT=16, cfg_table={3:0xC,2:0x9,1:0x5,0:0x2}, ld_mask=4'b1101.
- Reset release, ack after 3 cycles:
  - Expect reconfig_req high cycles 1-3, clock_config_S=0x2, line_doubler=1.
  - config_valid rises 8 cycles after ack, with a single config_changed pulse.
- force_vga=1 held:
  - Commit after 4 stable cycles: clock_config_S=0x5, line_doubler=0, drive_480p_low=1, active_mode=1.
  - Drop force_vga with sense_480p_n=1: return to mode 0 and drive_480p_low=0.
- Glitch: user_mode 0->2 for 3 cycles, then back to 0.
  - No reconfig_req and no config_changed.
  - Held 4 cycles: commit with 0x9.
- No ack:
  - reconfig_req drops after 16 cycles and ack_timeout_err=1 (sticky).
  - config_valid still rises after holdoff.
- Simultaneous ack and timeout on cycle 16: ack_timeout_err stays 0.
- Reset asserted during HOLDOFF of mode 3:
  - Outputs return to mode-0 values the next cycle and reconfig_req=1.
  - No config_changed pulse from the aborted sequence.
- user_mode changes during REQ: ignored until IDLE, then commits after 4 cycles.
